// File: rtl/qs_fifo_pkg.sv
// Shared definitions for the FIFO reader block.
//   DEFAULT_DATA_W : default payload width used by the reader and its buffer
//   BUF_DEPTH      : number of entries in the reader's output buffer
//   rd_state_e     : reader control states (IDLE, RUN, FLUSH)
package qs_fifo_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int BUF_DEPTH      = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } rd_state_e;

endpackage

// File: rtl/qs_skid_buf.sv
// Two-entry in-order buffer sitting between the FIFO pop side and the output
// stream. The head entry is always the oldest word.
//   clk, reset    : clock, synchronous active-low reset
//   clear_i       : drop all entries (occupancy -> 0)
//   push_i        : write push_data_i behind the newest entry
//   pop_i         : retire the head entry
//   head_data_o   : oldest entry
//   count_o       : occupancy, 0..2
module qs_skid_buf
    import qs_fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_data_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [1:0]        count_q, count_d;
    logic              do_push, do_pop;

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        do_pop  = pop_i && (count_q != 2'd0);
        // A push into a full buffer is only legal if the head leaves in the same cycle.
        do_push = push_i && ((count_q != 2'(BUF_DEPTH)) || do_pop);

        if (clear_i) begin
            count_d = 2'd0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10: begin
                    if (count_q == 2'd0) head_d = push_data_i;
                    else                 tail_d = push_data_i;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind whatever remains.
                    if (count_q == 2'd1) begin
                        head_d = push_data_i;
                    end else begin
                        head_d = tail_q;
                        tail_d = push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the data registers are reset too, so out_data reads zero after reset.
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_data_o = head_q;
    assign count_o     = count_q;

endmodule

// File: rtl/qs_fifo_reader.sv
// Pops words from a show-ahead FIFO and re-presents them as a valid/ready
// stream through a two-entry buffer, with flush and a handshake counter.
//   clk, reset       : clock, synchronous active-low reset
//   enable_i         : allow popping from the FIFO
//   flush_i          : discard buffered words and drain the FIFO
//   fifo_empty_i     : FIFO empty flag
//   fifo_pop_o       : pop strobe to the FIFO
//   fifo_pop_data_i  : FIFO head word (valid while not empty)
//   out_valid_o/out_data_o/out_ready_i : output stream
//   busy_o           : not IDLE or words still buffered
//   rd_count_o       : completed output handshakes, wrapping
//   flush_done_o     : one-cycle pulse after leaving FLUSH
module qs_fifo_reader
    import qs_fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_i,
    input  logic              flush_i,
    input  logic              fifo_empty_i,
    output logic              fifo_pop_o,
    input  logic [DATA_W-1:0] fifo_pop_data_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic [CNT_W-1:0]  rd_count_o,
    output logic              flush_done_o
);

    rd_state_e         state_q;
    logic              flush_done_q;
    logic [CNT_W-1:0]  rd_count_q, rd_count_d;
    logic [1:0]        occ;
    logic [DATA_W-1:0] head_data;
    logic              pop, handshake;

    // Pop decision uses registered occupancy only, so a full buffer never pops
    // even when the head is leaving this cycle.
    always_comb begin
        pop = 1'b0;
        if (reset && !fifo_empty_i) begin
            unique case (state_q)
                RUN:     pop = (occ < 2'(BUF_DEPTH));
                FLUSH:   pop = 1'b1;
                default: pop = 1'b0;
            endcase
        end
    end

    assign out_valid_o = (occ != 2'd0) && (state_q != FLUSH);
    assign handshake   = out_valid_o && out_ready_i;
    assign rd_count_d  = rd_count_q + CNT_W'(handshake);

    // Words popped in FLUSH are never pushed, and the buffer is held empty.
    qs_skid_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (state_q == FLUSH),
        .push_i      (pop && (state_q == RUN)),
        .push_data_i (fifo_pop_data_i),
        .pop_i       (handshake),
        .head_data_o (head_data),
        .count_o     (occ)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            flush_done_q <= 1'b0;
            rd_count_q   <= '0;
        end else begin
            rd_count_q   <= rd_count_d;
            flush_done_q <= 1'b0;
            if (flush_i) begin
                state_q <= FLUSH;
            end else begin
                unique case (state_q)
                    IDLE:  if (enable_i) state_q <= RUN;
                    RUN:   if (!enable_i) state_q <= IDLE;
                    FLUSH: begin
                        if (fifo_empty_i) begin
                            state_q      <= IDLE;
                            flush_done_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign fifo_pop_o   = pop;
    assign out_data_o   = head_data;
    assign busy_o       = (state_q != IDLE) || (occ != 2'd0);
    assign rd_count_o   = rd_count_q;
    assign flush_done_o = flush_done_q;

endmodule

// File: tb/tb_qs_fifo_reader.sv
// Self-checking bench for qs_fifo_reader: directed scenarios plus a random
// run, all compared cycle by cycle against a queue-based reference model.
module tb_qs_fifo_reader;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset, enable_i, flush_i, fifo_empty_i, out_ready_i;
    logic              fifo_pop_o, out_valid_o, busy_o, flush_done_o;
    logic [DATA_W-1:0] fifo_pop_data_i, out_data_o;
    logic [CNT_W-1:0]  rd_count_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    qs_fifo_reader #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable_i        (enable_i),
        .flush_i         (flush_i),
        .fifo_empty_i    (fifo_empty_i),
        .fifo_pop_o      (fifo_pop_o),
        .fifo_pop_data_i (fifo_pop_data_i),
        .out_valid_o     (out_valid_o),
        .out_data_o      (out_data_o),
        .out_ready_i     (out_ready_i),
        .busy_o          (busy_o),
        .rd_count_o      (rd_count_o),
        .flush_done_o    (flush_done_o)
    );

    // Environment FIFO contents and reference model.
    typedef enum {M_IDLE, M_RUN, M_FLUSH} mode_e;
    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] m_buf[$];
    mode_e             m_mode;
    logic [CNT_W-1:0]  m_count;
    logic              m_done;
    bit                checking = 1'b0;

    // Observations of the DUT used by the directed scenarios.
    int                dut_pops, dut_done_pulses, dut_valid_cycles;
    logic [DATA_W-1:0] got_q[$];

    // One clock cycle: present the FIFO, compare outputs, advance the model.
    // Called and returns at a negedge with the stimulus inputs already driven.
    task automatic cycle(input string tag);
        logic e_pop, e_valid, e_busy, hs;
        fifo_empty_i    = (fifo_q.size() == 0);
        fifo_pop_data_i = fifo_empty_i ? DATA_W'($urandom) : fifo_q[0];
        #1;
        e_pop   = reset && (fifo_q.size() != 0) &&
                  ((m_mode == M_RUN && m_buf.size() < 2) || m_mode == M_FLUSH);
        e_valid = (m_buf.size() != 0) && (m_mode != M_FLUSH);
        e_busy  = (m_mode != M_IDLE) || (m_buf.size() != 0);
        if (checking) begin
            checks++;
            if (fifo_pop_o !== e_pop) begin
                errors++; $display("FAIL %s pop: got %b want %b", tag, fifo_pop_o, e_pop);
            end
            checks++;
            if (out_valid_o !== e_valid) begin
                errors++; $display("FAIL %s valid: got %b want %b", tag, out_valid_o, e_valid);
            end
            if (e_valid) begin
                checks++;
                if (out_data_o !== m_buf[0]) begin
                    errors++; $display("FAIL %s data: got %h want %h", tag, out_data_o, m_buf[0]);
                end
            end
            checks++;
            if (busy_o !== e_busy) begin
                errors++; $display("FAIL %s busy: got %b want %b", tag, busy_o, e_busy);
            end
            checks++;
            if (rd_count_o !== m_count) begin
                errors++; $display("FAIL %s rd_count: got %0d want %0d", tag, rd_count_o, m_count);
            end
            checks++;
            if (flush_done_o !== m_done) begin
                errors++; $display("FAIL %s flush_done: got %b want %b", tag, flush_done_o, m_done);
            end
        end
        if (fifo_pop_o === 1'b1) dut_pops++;
        if (flush_done_o === 1'b1) dut_done_pulses++;
        if (out_valid_o === 1'b1) dut_valid_cycles++;
        if (out_valid_o === 1'b1 && out_ready_i) got_q.push_back(out_data_o);
        hs = e_valid && out_ready_i;

        @(posedge clk);
        if (!reset) begin
            m_mode  = M_IDLE;
            m_buf.delete();
            m_count = '0;
            m_done  = 1'b0;
        end else begin
            m_done = (m_mode == M_FLUSH) && !flush_i && (fifo_q.size() == 0);
            if (m_mode == M_FLUSH) begin
                m_buf.delete();
            end else begin
                if (hs) void'(m_buf.pop_front());
                if (e_pop) m_buf.push_back(fifo_q[0]);
            end
            if (hs) m_count++;
            if (flush_i) m_mode = M_FLUSH;
            else if (m_mode == M_IDLE && enable_i) m_mode = M_RUN;
            else if (m_mode == M_RUN && !enable_i) m_mode = M_IDLE;
            else if (m_mode == M_FLUSH && fifo_q.size() == 0) m_mode = M_IDLE;
        end
        if (e_pop) void'(fifo_q.pop_front());
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; enable_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0;
        fifo_q = {8'h5A};
        cycle("reset0");
        checking = 1'b1;
        cycle("reset1");
        checks++;
        if (out_data_o !== 8'h00) begin
            errors++; $display("FAIL reset_data: got %h want 00", out_data_o);
        end
        checks++;
        if (fifo_pop_o !== 1'b0) begin
            errors++; $display("FAIL reset_pop: got %b want 0", fifo_pop_o);
        end
        reset = 1'b1; enable_i = 1'b0; fifo_q.delete();
        cycle("reset_rel");
    endtask

    task automatic test_basic();
        fifo_q = {8'hAB, 8'hCC}; enable_i = 1'b1; out_ready_i = 1'b1;
        dut_pops = 0; got_q.delete();
        cycle("basic"); cycle("basic");
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 8'hAB) begin
            errors++; $display("FAIL basic_latency: got %b/%h want 1/ab", out_valid_o, out_data_o);
        end
        cycle("basic");
        checks++;
        if (dut_pops != 2) begin
            errors++; $display("FAIL basic_pops: got %0d want 2", dut_pops);
        end
        repeat (3) cycle("basic");
        checks++;
        if (got_q.size() != 2 || got_q[0] !== 8'hAB || got_q[1] !== 8'hCC) begin
            errors++; $display("FAIL basic_order: got %p want AB CC", got_q);
        end
        checks++;
        if (rd_count_o !== 16'd2) begin
            errors++; $display("FAIL basic_count: got %0d want 2", rd_count_o);
        end
    endtask

    task automatic test_backpressure();
        out_ready_i = 1'b0; fifo_q = {8'hAB, 8'hCC, 8'hDD};
        dut_pops = 0;
        repeat (5) cycle("bp_stall");
        checks++;
        if (dut_pops != 2 || fifo_pop_o !== 1'b0) begin
            errors++; $display("FAIL bp_pops: got %0d/%b want 2/0", dut_pops, fifo_pop_o);
        end
        checks++;
        if (out_data_o !== 8'hAB) begin
            errors++; $display("FAIL bp_hold: got %h want ab", out_data_o);
        end
        out_ready_i = 1'b1; got_q.delete();
        repeat (5) cycle("bp_drain");
        checks++;
        if (got_q.size() != 3 || got_q[0] !== 8'hAB || got_q[1] !== 8'hCC || got_q[2] !== 8'hDD) begin
            errors++; $display("FAIL bp_order: got %p want AB CC DD", got_q);
        end
        checks++;
        if (rd_count_o !== 16'd5) begin
            errors++; $display("FAIL bp_count: got %0d want 5", rd_count_o);
        end
    endtask

    task automatic test_flush();
        out_ready_i = 1'b0; fifo_q = {8'h11, 8'h22, 8'h33};
        repeat (3) cycle("fl_fill");
        enable_i = 1'b0; flush_i = 1'b1; dut_pops = 0; dut_done_pulses = 0;
        cycle("fl_req");
        flush_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++; $display("FAIL fl_valid: got %b want 0", out_valid_o);
        end
        repeat (5) cycle("fl_run");
        checks++;
        if (dut_pops != 1) begin
            errors++; $display("FAIL fl_pops: got %0d want 1", dut_pops);
        end
        checks++;
        if (dut_done_pulses != 1) begin
            errors++; $display("FAIL fl_done: got %0d pulses want 1", dut_done_pulses);
        end
        checks++;
        if (rd_count_o !== 16'd5 || busy_o !== 1'b0) begin
            errors++; $display("FAIL fl_after: got count %0d busy %b want 5/0", rd_count_o, busy_o);
        end
    endtask

    task automatic test_enable_drop();
        enable_i = 1'b1; out_ready_i = 1'b0; fifo_q = {8'hAB, 8'hCC};
        repeat (3) cycle("en_fill");
        enable_i = 1'b0; fifo_q.push_back(8'hEE); dut_pops = 0; got_q.delete();
        cycle("en_drop");
        out_ready_i = 1'b1;
        repeat (4) cycle("en_drain");
        checks++;
        if (dut_pops != 0) begin
            errors++; $display("FAIL en_pops: got %0d want 0", dut_pops);
        end
        checks++;
        if (got_q.size() != 2 || got_q[0] !== 8'hAB || got_q[1] !== 8'hCC) begin
            errors++; $display("FAIL en_order: got %p want AB CC", got_q);
        end
        checks++;
        if (rd_count_o !== 16'd7) begin
            errors++; $display("FAIL en_count: got %0d want 7", rd_count_o);
        end
    endtask

    task automatic test_reset_mid();
        enable_i = 1'b1; out_ready_i = 1'b0; fifo_q.push_back(8'hFF);
        repeat (3) cycle("rm_fill");
        fifo_q.push_back(8'h77);
        reset = 1'b0;
        cycle("rm_reset");
        checks++;
        if (out_valid_o !== 1'b0 || out_data_o !== 8'h00 || busy_o !== 1'b0 ||
            flush_done_o !== 1'b0 || fifo_pop_o !== 1'b0) begin
            errors++; $display("FAIL rm_outputs: got v%b d%h b%b f%b p%b want all 0",
                               out_valid_o, out_data_o, busy_o, flush_done_o, fifo_pop_o);
        end
        checks++;
        if (rd_count_o !== 16'd0) begin
            errors++; $display("FAIL rm_count: got %0d want 0", rd_count_o);
        end
        enable_i = 1'b0; fifo_q.delete();
        reset = 1'b1;
        cycle("rm_rel");
    endtask

    task automatic test_empty();
        enable_i = 1'b1; dut_pops = 0; dut_valid_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            out_ready_i = 1'($urandom);
            cycle("empty");
        end
        checks++;
        if (dut_pops != 0 || dut_valid_cycles != 0) begin
            errors++; $display("FAIL empty: got pops %0d valid %0d want 0/0", dut_pops, dut_valid_cycles);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 8) fifo_q.push_back(DATA_W'($urandom));
            enable_i    = ($urandom_range(0, 9) != 0);
            flush_i     = ($urandom_range(0, 49) == 0);
            out_ready_i = ($urandom_range(0, 2) != 0);
            reset       = ($urandom_range(0, 299) != 0);
            cycle("random");
        end
        reset = 1'b1; flush_i = 1'b0;
    endtask

    initial begin
        reset = 1'b0; enable_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
        fifo_empty_i = 1'b1; fifo_pop_data_i = '0;
        m_mode = M_IDLE; m_count = '0; m_done = 1'b0;
        dut_pops = 0; dut_done_pulses = 0; dut_valid_cycles = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_flush();
        test_enable_drop();
        test_reset_mid();
        test_empty();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qs_fifo_reader.md
QS_FIFO_READER -- requirements
Module: qs_fifo_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width in bits.
REQ-002 SHALL have parameter CNT_W, default 16, width of the delivered-word counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port enable_i  input  1  permits reading from the FIFO when high.
REQ-006 SHALL have port flush_i  input  1  requests discard of all FIFO and buffered data.
REQ-007 SHALL have port fifo_empty_i  input  1  FIFO empty flag.
REQ-008 SHALL have port fifo_pop_o  output  1  pop strobe to the FIFO.
REQ-009 SHALL have port fifo_pop_data_i  input  DATA_W  FIFO head data, valid combinationally whenever fifo_empty_i=0.
REQ-010 SHALL have port out_valid_o  output  1  output stream valid.
REQ-011 SHALL have port out_data_o  output  DATA_W  output stream data.
REQ-012 SHALL have port out_ready_i  input  1  downstream ready.
REQ-013 SHALL have port busy_o  output  1  state not IDLE or buffer non-empty.
REQ-014 SHALL have port rd_count_o  output  CNT_W  count of completed output handshakes.
REQ-015 SHALL have port flush_done_o  output  1  one-cycle pulse when a flush completes.

Function
REQ-016 SHALL implement states IDLE, RUN, FLUSH.
REQ-017 SHALL transition: any state -> FLUSH when flush_i=1 (highest priority); IDLE -> RUN when enable_i=1; RUN -> IDLE when enable_i=0; FLUSH -> IDLE when fifo_empty_i=1 and flush_i=0.
REQ-018 SHALL hold a 2-entry output buffer (occupancy 0..2); out_valid_o=1 iff occupancy>0 and state!=FLUSH; out_data_o = oldest entry.
REQ-019 SHALL assert fifo_pop_o in RUN iff fifo_empty_i=0 and registered occupancy<2; in FLUSH iff fifo_empty_i=0; never in IDLE.
REQ-020 SHALL never assert fifo_pop_o while fifo_empty_i=1.
REQ-021 SHALL write fifo_pop_data_i into the buffer at the posedge where fifo_pop_o=1 in RUN; pop and output handshake in the same cycle SHALL leave occupancy unchanged.
REQ-022 SHALL present a popped word on out_valid_o the cycle after the pop (latency 1); sustain one word per cycle with out_ready_i=1.
REQ-023 SHALL keep out_valid_o high and out_data_o stable until out_valid_o and out_ready_i are both high, except on flush.
REQ-024 SHALL deliver words in FIFO order, none dropped or duplicated outside flush.
REQ-025 SHALL, on entry to FLUSH, clear buffer occupancy to 0 on the first FLUSH posedge; popped words in FLUSH SHALL be discarded.
REQ-026 SHALL pulse flush_done_o for exactly the cycle after FLUSH -> IDLE.
REQ-027 SHALL keep buffered words presented in IDLE entered from RUN (draining continues, no new pops).
REQ-028 SHALL increment rd_count_o by 1 per output handshake, wrapping modulo 2^CNT_W; flush SHALL not alter it.

Reset
REQ-029 SHALL, when reset=0 at a posedge, set state IDLE, occupancy 0, out_valid_o=0, out_data_o=0, rd_count_o=0, flush_done_o=0, busy_o=0; fifo_pop_o=0 while reset=0.
REQ-030 SHALL apply reset mid-operation identically, discarding buffered words.

Structure
REQ-031 SHALL take state typedef rd_state_e (IDLE, RUN, FLUSH) from shared package qs_fifo_pkg, along with default DATA_W.
REQ-032 SHALL implement the 2-entry buffer as sub-module qs_skid_buf (push, pop, clear, occupancy).

Verification
REQ-033 Enable=1, FIFO holds AB, CC, ready=1 -> pops on 2 consecutive cycles; out AB then CC one cycle later each; rd_count_o=2.
REQ-034 ready=0, FIFO holds AB, CC, DD -> exactly 2 pops, then fifo_pop_o=0, out_data_o stays AB; ready=1 -> AB, CC, DD delivered in order, rd_count_o=3.
REQ-035 Buffer holds 2, FIFO holds 1, flush_i pulsed 1 cycle -> out_valid_o=0 next cycle, 1 pop, flush_done_o single pulse, rd_count_o unchanged, busy_o=0 after.
REQ-036 Buffer holds AB, CC, enable_i dropped -> no further pops; AB, CC still delivered.
REQ-037 reset=0 with occupancy 2 -> next cycle all outputs zero, rd_count_o=0.
REQ-038 FIFO empty throughout with enable_i=1 -> fifo_pop_o never asserted, out_valid_o=0.
